alu_seq_mul: RTL

ALU_SEQ_MUL -- requirements
Module: alu_seq_mul

---
 rtl/alu_seq_mul_pkg.sv | 13 +
 rtl/alu_mul_datapath.sv | 51 +++++
 rtl/alu_seq_mul.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding is fixed so that 2'b11 is the only illegal code.
package alu_seq_mul_pkg;

    localparam int WORD_SIZE_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_mul_datapath.sv
// Shift-add datapath: multiplicand, {carry, acc_hi, acc_lo} accumulator and adder.
// One iteration per i_step edge; o_nxt_* is the accumulator after the current iteration.
module alu_mul_datapath #(
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [word_size-1:0] i_a,
    input  logic [word_size-1:0] i_b,
    output logic [word_size-1:0] o_nxt_hi,
    output logic [word_size-1:0] o_nxt_lo
);

    logic [word_size-1:0] r_mcand;
    logic [word_size-1:0] r_acc_hi;
    logic [word_size-1:0] r_acc_lo;
    logic                 r_carry;
    logic [word_size:0]   w_sum;

    always_comb begin
        w_sum = {r_carry, r_acc_hi};
        if (r_acc_lo[0]) begin
            w_sum = {1'b0, r_acc_hi} + {1'b0, r_mcand};
        end
    end

    // Right shift of {carry, acc_hi, acc_lo}: the carry lands in the MSB of acc_hi.
    assign o_nxt_hi = w_sum[word_size:1];
    assign o_nxt_lo = {w_sum[0], r_acc_lo[word_size-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_carry  <= 1'b0;
        end else if (i_load) begin
            r_mcand  <= i_a;
            r_acc_lo <= i_b;
            r_acc_hi <= '0;
            r_carry  <= 1'b0;
        end else if (i_step) begin
            r_acc_hi <= o_nxt_hi;
            r_acc_lo <= o_nxt_lo;
            r_carry  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_mul.sv
// Unsigned word_size x word_size sequential multiplier, full 2*word_size product.
// done pulses word_size edges after start is accepted; start is ignored while busy.
module alu_seq_mul
    import alu_seq_mul_pkg::*;
#(
    parameter int word_size = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [word_size-1:0] A,
    input  logic [word_size-1:0] B,
    output logic [word_size-1:0] P_lo,
    output logic [word_size-1:0] P_hi,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = (word_size > 1) ? $clog2(word_size) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(word_size - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [word_size-1:0] r_p_hi;
    logic [word_size-1:0] r_p_lo;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_step;
    logic [word_size-1:0] w_nxt_hi;
    logic [word_size-1:0] w_nxt_lo;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_step   = (r_state == ST_RUN);

    alu_mul_datapath #(
        .word_size (word_size)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_a      (A),
        .i_b      (B),
        .o_nxt_hi (w_nxt_hi),
        .o_nxt_lo (w_nxt_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_p_hi  <= '0;
            r_p_lo  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    r_cnt  <= '0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The last iteration's result goes straight into P from the adder.
                    if (r_cnt == CNT_LAST) begin
                        r_p_hi  <= w_nxt_hi;
                        r_p_lo  <= w_nxt_lo;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign P_hi = r_p_hi;
    assign P_lo = r_p_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule
